// File: rtl/mips_alu_unit_if.sv
// Operand/result bundle for the MIPS ALU and address adder.
// The master drives operation and operands; the slave returns the registered results.
interface mips_alu_unit_if #(
   parameter int WIDTH = 32
);
   logic [1:0]       alu_op;
   logic [5:0]       funct;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [3:0]       alu_ctl;
   logic [WIDTH-1:0] alu_res;
   logic             zero;
   logic             cout;
   logic             ovf;
   logic [WIDTH-1:0] sum;

   modport master (
      output alu_op, funct, a, b, cin, add_a, add_b,
      input  alu_ctl, alu_res, zero, cout, ovf, sum
   );

   modport slave (
      input  alu_op, funct, a, b, cin, add_a, add_b,
      output alu_ctl, alu_res, zero, cout, ovf, sum
   );
endinterface

// File: rtl/mips_alu_unit.sv
// MIPS ALU with ALU-control decode and an independent address adder.
// Every output is registered, so results appear exactly one cycle after their inputs.
module mips_alu_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   mips_alu_unit_if.slave     bus
);
   localparam logic [3:0] CTL_AND = 4'b0000;
   localparam logic [3:0] CTL_OR  = 4'b0001;
   localparam logic [3:0] CTL_ADD = 4'b0010;
   localparam logic [3:0] CTL_SUB = 4'b0110;
   localparam logic [3:0] CTL_SLT = 4'b0111;
   localparam logic [3:0] CTL_NOR = 4'b1100;
   localparam logic [3:0] CTL_XOR = 4'b1101;

   function automatic logic [3:0] decode_ctl(input logic [1:0] op, input logic [5:0] fn);
      logic [3:0] ctl;
      case (op)
         2'b00:   ctl = CTL_ADD;
         2'b01:   ctl = CTL_SUB;
         2'b11:   ctl = CTL_OR;
         2'b10: begin
            case (fn)
               6'b100000: ctl = CTL_ADD;
               6'b100010: ctl = CTL_SUB;
               6'b100100: ctl = CTL_AND;
               6'b100101: ctl = CTL_OR;
               6'b100110: ctl = CTL_XOR;
               6'b100111: ctl = CTL_NOR;
               6'b101010: ctl = CTL_SLT;
               default:   ctl = CTL_ADD;
            endcase
         end
         default: ctl = CTL_ADD;
      endcase
      return ctl;
   endfunction

   logic [3:0]       ctl_s;
   logic [WIDTH-1:0] res_s;
   logic             cout_s;
   logic             ovf_s;
   logic [WIDTH-1:0] sum_s;
   logic [WIDTH:0]   wide_s;

   logic [3:0]       ctl_r;
   logic [WIDTH-1:0] res_r;
   logic             zero_r;
   logic             cout_r;
   logic             ovf_r;
   logic [WIDTH-1:0] sum_r;

   // Operation decode from main-control class and function field.
   always_comb begin
      ctl_s = decode_ctl(bus.alu_op, bus.funct);
   end

   // Datapath: one shared (WIDTH+1)-bit adder result feeds ADD/SUB carry and overflow.
   always_comb begin
      res_s  = {WIDTH{1'b0}};
      cout_s = 1'b0;
      ovf_s  = 1'b0;
      wide_s = {(WIDTH+1){1'b0}};
      case (ctl_s)
         CTL_ADD: begin
            wide_s = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
            res_s  = wide_s[WIDTH-1:0];
            cout_s = wide_s[WIDTH];
            ovf_s  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (res_s[WIDTH-1] != bus.a[WIDTH-1]);
         end
         CTL_SUB: begin
            wide_s = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
            res_s  = wide_s[WIDTH-1:0];
            cout_s = wide_s[WIDTH];
            ovf_s  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (res_s[WIDTH-1] != bus.a[WIDTH-1]);
         end
         CTL_AND: res_s = bus.a & bus.b;
         CTL_OR:  res_s = bus.a | bus.b;
         CTL_XOR: res_s = bus.a ^ bus.b;
         CTL_NOR: res_s = ~(bus.a | bus.b);
         // Signed compare directly, so an overflowing a-b cannot flip the answer.
         CTL_SLT: begin
            if ($signed(bus.a) < $signed(bus.b)) begin
               res_s = {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
               res_s = {WIDTH{1'b0}};
            end
         end
         default: begin
            res_s  = {WIDTH{1'b0}};
            cout_s = 1'b0;
            ovf_s  = 1'b0;
         end
      endcase
   end

   // Address adder, independent of the ALU operation.
   always_comb begin
      sum_s = bus.add_a + bus.add_b;
   end

   // Output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctl_r  <= 4'b0000;
         res_r  <= {WIDTH{1'b0}};
         zero_r <= 1'b1;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
         sum_r  <= {WIDTH{1'b0}};
      end else begin
         ctl_r  <= ctl_s;
         res_r  <= res_s;
         zero_r <= (res_s == {WIDTH{1'b0}});
         cout_r <= cout_s;
         ovf_r  <= ovf_s;
         sum_r  <= sum_s;
      end
   end

   assign bus.alu_ctl = ctl_r;
   assign bus.alu_res = res_r;
   assign bus.zero    = zero_r;
   assign bus.cout    = cout_r;
   assign bus.ovf     = ovf_r;
   assign bus.sum     = sum_r;
endmodule

// File: tb/tb_mips_alu_unit.sv
// Self-checking bench for mips_alu_unit: directed corner cases then randomized
// operations, each checked against an arithmetic reference model one cycle later.
module tb_mips_alu_unit;
   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   mips_alu_unit_if #(.WIDTH(32)) bus ();

   mips_alu_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: decode expressed as a lookup of named operations.
   function automatic logic [3:0] ref_ctl(input logic [1:0] op, input logic [5:0] fn);
      if (op == 2'd0) return 4'd2;
      if (op == 2'd1) return 4'd6;
      if (op == 2'd3) return 4'd1;
      if (fn == 6'd32) return 4'd2;
      if (fn == 6'd34) return 4'd6;
      if (fn == 6'd36) return 4'd0;
      if (fn == 6'd37) return 4'd1;
      if (fn == 6'd38) return 4'd13;
      if (fn == 6'd39) return 4'd12;
      if (fn == 6'd42) return 4'd7;
      return 4'd2;
   endfunction

   // Reference: integer arithmetic on 64-bit values, overflow as a range check.
   task automatic ref_alu(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, output logic [31:0] res, output logic co,
                          output logic ov);
      longint ua, ub, u, sa, sb, s;
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = 32'd0; co = 1'b0; ov = 1'b0;
      u = 64'sd0; s = 64'sd0;
      case (ctl)
         4'd2: begin
            u = ua + ub + longint'(cin);
            s = sa + sb + longint'(cin);
            res = u[31:0]; co = u[32];
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd6: begin
            u = ua + (64'sd4294967295 - ub) + 64'sd1;
            s = sa - sb;
            res = u[31:0]; co = u[32];
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd0:  res = a & b;
         4'd1:  res = a | b;
         4'd13: res = a ^ b;
         4'd12: res = ~(a | b);
         4'd7:  res = (sa < sb) ? 32'd1 : 32'd0;
         default: res = 32'd0;
      endcase
   endtask

   // One operation: drive at negedge, check everything just after the next rising edge.
   task automatic do_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic [31:0] aa, input logic [31:0] ab);
      logic [3:0]  e_ctl;
      logic [31:0] e_res;
      logic        e_co, e_ov;
      logic [31:0] e_sum;
      @(negedge clk);
      bus.alu_op = op; bus.funct = fn; bus.a = a; bus.b = b; bus.cin = cin;
      bus.add_a = aa; bus.add_b = ab;
      e_ctl = ref_ctl(op, fn);
      ref_alu(e_ctl, a, b, cin, e_res, e_co, e_ov);
      e_sum = aa + ab;
      @(posedge clk);
      #1;
      chk({tag, "_ctl"},  {28'd0, bus.alu_ctl}, {28'd0, e_ctl});
      chk({tag, "_res"},  bus.alu_res, e_res);
      chk({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, (e_res == 32'd0)});
      chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, e_co});
      chk({tag, "_ovf"},  {31'd0, bus.ovf},  {31'd0, e_ov});
      chk({tag, "_sum"},  bus.sum, e_sum);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ctl"},  {28'd0, bus.alu_ctl}, 32'd0);
      chk({tag, "_res"},  bus.alu_res, 32'd0);
      chk({tag, "_zero"}, {31'd0, bus.zero}, 32'd1);
      chk({tag, "_cout"}, {31'd0, bus.cout}, 32'd0);
      chk({tag, "_ovf"},  {31'd0, bus.ovf},  32'd0);
      chk({tag, "_sum"},  bus.sum, 32'd0);
   endtask

   initial begin
      logic [5:0]  fn_tab [8];
      logic [31:0] edge_tab [6];
      logic [31:0] ra, rb;
      logic [5:0]  rf;
      fn_tab   = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd0};
      edge_tab = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                   32'h0000_0001, 32'h8000_0001};

      // Reset with a live operation presented: reset must win.
      reset = 1'b1;
      bus.alu_op = 2'b00; bus.funct = 6'd0; bus.a = 32'h1234_5678; bus.b = 32'h1111_1111;
      bus.cin = 1'b1; bus.add_a = 32'h0040_0000; bus.add_b = 32'h0000_0004;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_reset("reset");
      @(negedge clk);
      reset = 1'b0;

      do_op("add_ovf", 2'b00, 6'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h0040_0000, 32'd4);
      chk("add_ovf_const_res", bus.alu_res, 32'h8000_0000);
      chk("add_ovf_const_ovf", {31'd0, bus.ovf}, 32'd1);
      chk("adr_const_sum", bus.sum, 32'h0040_0004);
      do_op("add_wrap", 2'b00, 6'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFC, 32'd8);
      chk("add_wrap_const_cout", {31'd0, bus.cout}, 32'd1);
      chk("add_wrap_const_zero", {31'd0, bus.zero}, 32'd1);
      chk("adr_wrap_const_sum", bus.sum, 32'h0000_0004);
      do_op("add_cin", 2'b00, 6'd0, 32'h7FFF_FFFE, 32'd1, 1'b1, 32'd0, 32'd0);
      do_op("sub_eq", 2'b01, 6'd0, 32'd5, 32'd5, 1'b1, 32'd1, 32'd2);
      chk("sub_eq_const_cout", {31'd0, bus.cout}, 32'd1);
      do_op("sub_ovf", 2'b01, 6'd0, 32'h8000_0000, 32'd1, 1'b0, 32'd3, 32'd4);
      chk("sub_ovf_const_res", bus.alu_res, 32'h7FFF_FFFF);
      do_op("slt_neg", 2'b10, 6'b101010, 32'h8000_0000, 32'd1, 1'b0, 32'd0, 32'd0);
      chk("slt_neg_const", bus.alu_res, 32'd1);
      do_op("slt_pos", 2'b10, 6'b101010, 32'd1, 32'h8000_0000, 1'b0, 32'd0, 32'd0);
      do_op("and", 2'b10, 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'd0, 32'd0);
      chk("and_const", bus.alu_res, 32'h00F0_00F0);
      do_op("or",  2'b10, 6'b100101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'd0, 32'd0);
      chk("or_const", bus.alu_res, 32'hFFF0_FFF0);
      do_op("xor", 2'b10, 6'b100110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'd0, 32'd0);
      chk("xor_const", bus.alu_res, 32'hFF00_FF00);
      do_op("nor", 2'b10, 6'b100111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'd0, 32'd0);
      chk("nor_const", bus.alu_res, 32'h000F_000F);
      do_op("fn_undef", 2'b10, 6'b111111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'd0, 32'd0);
      chk("fn_undef_ctl", {28'd0, bus.alu_ctl}, 32'd2);
      do_op("op_or", 2'b11, 6'b100010, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0, 32'd9, 32'd9);

      for (int i = 0; i < 300; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? edge_tab[$urandom_range(0, 5)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? edge_tab[$urandom_range(0, 5)] : $urandom;
         rf = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 7)];
         do_op("rand", 2'($urandom), rf, ra, rb, 1'($urandom), $urandom, $urandom);
      end

      // Mid-stream reset clears results again.
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk_reset("reset2");
      @(negedge clk);
      reset = 1'b0;
      do_op("post_reset", 2'b01, 6'd0, 32'd3, 32'd7, 1'b0, 32'd100, 32'd28);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mips_alu_unit.md
MIPS_ALU_UNIT -- requirements
Module: mips_alu_unit

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width of the ALU and adder; all widths below assume 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 alu_op  input  2  ALU operation class from main control.
REQ-005 funct  input  6  R-type function field.
REQ-006 a  input  32  ALU operand A.
REQ-007 b  input  32  ALU operand B.
REQ-008 cin  input  1  carry-in, used by ADD only.
REQ-009 add_a  input  32  address-adder operand A.
REQ-010 add_b  input  32  address-adder operand B.
REQ-011 alu_ctl  output  4  registered decoded ALU control code.
REQ-012 alu_res  output  32  registered ALU result.
REQ-013 zero  output  1  registered, high when alu_res is all zeros.
REQ-014 cout  output  1  registered carry-out.
REQ-015 ovf  output  1  registered signed overflow.
REQ-016 sum  output  32  registered add_a + add_b.

Function
REQ-017 Decode (combinational): alu_op 00 -> 0010 ADD; 01 -> 0110 SUB; 11 -> 0001 OR; 10 -> decode funct.
REQ-018 funct decode: 100000 ADD 0010; 100010 SUB 0110; 100100 AND 0000; 100101 OR 0001; 100110 XOR 1101; 100111 NOR 1100; 101010 SLT 0111; any other funct -> ADD 0010.
REQ-019 ADD: result = a + b + cin mod 2^32; cout = bit 32 of the sum; ovf = a[31]==b[31] and result[31]!=a[31].
REQ-020 SUB: result = a + ~b + 1 (cin ignored); cout = bit 32 of that sum (1 means no borrow); ovf = a[31]!=b[31] and result[31]!=a[31].
REQ-021 AND, OR, XOR, NOR: bitwise on a, b; cout = 0, ovf = 0.
REQ-022 SLT: result = 32'd1 if signed a < signed b, else 0; must be correct even when a-b overflows; cout = 0, ovf = 0.
REQ-023 Any undefined alu_ctl value yields result 0, cout 0, ovf 0.
REQ-024 zero = 1 exactly when the registered alu_res equals 0, computed from the same-cycle result.
REQ-025 Adder: sum = add_a + add_b mod 2^32, no carry output; independent of alu_op/funct.
REQ-026 Latency: inputs sampled at rising edge N appear on all outputs after edge N; exactly one cycle, no handshake, new operation accepted every cycle.
REQ-027 alu_ctl output is the decode of the same sampled alu_op/funct that produced alu_res.

Reset
REQ-028 When reset is high at a rising edge: alu_ctl = 0000, alu_res = 0, cout = 0, ovf = 0, sum = 0, zero = 1.
REQ-029 Reset overrides the operation presented in the same cycle; the first post-reset result appears one cycle after reset deasserts with valid inputs.
REQ-030 Outputs are undefined only before the first reset edge; no asynchronous behaviour.

Verification
REQ-031 reset=1 one edge -> alu_res 0, zero 1, cout 0, ovf 0, sum 0, alu_ctl 0000.
REQ-032 alu_op 00, a=0x7FFFFFFF, b=1, cin=0 -> next cycle alu_res 0x80000000, ovf 1, cout 0, zero 0, alu_ctl 0010; with a=0xFFFFFFFF, b=1 -> alu_res 0, cout 1, ovf 0, zero 1.
REQ-033 alu_op 01, a=5, b=5 -> alu_res 0, zero 1, cout 1; a=0x80000000, b=1 -> alu_res 0x7FFFFFFF, ovf 1.
REQ-034 alu_op 10, funct 101010, a=0x80000000, b=1 -> alu_res 1; a=1, b=0x80000000 -> alu_res 0, zero 1.
REQ-035 alu_op 10, a=0xF0F0F0F0, b=0x0FF00FF0: funct 100100 -> 0x00F000F0; 100101 -> 0xFFF0FFF0; 100110 -> 0xFF00FF00; 100111 -> 0x000F000F; funct 111111 -> ADD, alu_ctl 0010.
REQ-036 add_a=0x00400000, add_b=0x00000004 -> sum 0x00400004; add_a=0xFFFFFFFC, add_b=8 -> sum 0x00000004; back-to-back operations each produce results exactly one cycle later.
